// File: rtl/dottori_raster_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dottori_raster_gen                                         |
// | Description : Raster timing, VRAM bitmap fetch, 1/2 bpp serialiser with  |
// |               4-entry palette, CPU VRAM wait and V-blank interrupt.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dottori_raster_gen #(
  parameter int H_ACTIVE       = 256,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 24,
  parameter int H_BP           = 24,
  parameter int V_ACTIVE       = 256,
  parameter int V_FP           = 8,
  parameter int V_SYNC         = 4,
  parameter int V_BP           = 20,
  parameter int BPP            = 1,
  parameter int CPU_BLANK_ONLY = 0,
  parameter int ADDR_W         = 13
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic              vram_rd_o,
  input  logic [7:0]        vram_data_i,
  input  logic              cpu_vram_req_i,
  output logic              cpu_wait_o,
  input  logic              pal_wr_i,
  input  logic [1:0]        pal_idx_i,
  input  logic [2:0]        pal_data_i,
  input  logic              irq_ack_i,
  output logic              red_o,
  output logic              green_o,
  output logic              blue_o,
  output logic              h_sync_o,
  output logic              v_sync_o,
  output logic              h_blank_o,
  output logic              v_blank_o,
  output logic              sync_o,
  output logic              irq_n_o
);

  localparam int PPB     = 8 / BPP;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PW      = $clog2(PPB);

  logic [HW-1:0]     hcount_q, hcount_d;
  logic [VW-1:0]     vcount_q, vcount_d;
  logic              vram_rd_q, rd_dly_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        shift_q;
  logic [2:0]        pal_q [4];
  logic [1:0]        pix_idx;
  logic [2:0]        rgb_q, rgb_d;
  logic              hblank_q, vblank_q, hsync_q, vsync_q, sync_q, irq_q, irq_d;
  logic              hblank_d, vblank_d, hsync_d, vsync_d;
  logic              irq_set, irq_end;

  // A byte is requested two cycles before its first pixel position; byte 0 of
  // a line is therefore requested at the end of the previous line.
  function automatic logic fetch_at(input logic [HW-1:0] h, input logic [VW-1:0] v);
    logic prefetch, in_line;
    prefetch = (h == HW'(H_TOTAL - 2)) &&
               ((v == VW'(V_TOTAL - 1)) || (v < VW'(V_ACTIVE - 1)));
    in_line  = (v < VW'(V_ACTIVE)) && (h < HW'(H_ACTIVE - 2)) &&
               (h[PW-1:0] == PW'(PPB - 2));
    return prefetch || in_line;
  endfunction

  // Next counter position.
  always_comb begin
    hcount_d = hcount_q + HW'(1);
    vcount_d = vcount_q;
    if (hcount_q == HW'(H_TOTAL - 1)) begin
      hcount_d = '0;
      vcount_d = (vcount_q == VW'(V_TOTAL - 1)) ? '0 : vcount_q + VW'(1);
    end
  end

  // Raster counters; reset parks on the last line so line 0 gets its prefetch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hcount_q <= '0;
      vcount_q <= VW'(V_TOTAL - 1);
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  // Address restarts at the line-0 byte-0 request and steps once per request.
  always_comb begin
    addr_d = addr_q;
    if ((hcount_d == HW'(H_TOTAL - 2)) && (vcount_d == VW'(V_TOTAL - 1)))
      addr_d = '0;
    else if (vram_rd_q)
      addr_d = addr_q + ADDR_W'(1);
  end

  // Fetch strobe is decoded from the next position so it leaves a flop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vram_rd_q <= 1'b0;
      rd_dly_q  <= 1'b0;
      addr_q    <= '0;
    end else begin
      vram_rd_q <= fetch_at(hcount_d, vcount_d);
      rd_dly_q  <= vram_rd_q;
      addr_q    <= addr_d;
    end
  end

  // Shifter loads the byte returned for the previous request, else shifts.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      shift_q <= '0;
    else if (rd_dly_q)
      shift_q <= vram_data_i;
    else
      shift_q <= shift_q << BPP;
  end

  generate
    if (BPP == 1) begin : g_idx_1bpp
      assign pix_idx = {1'b0, shift_q[7]};
    end else begin : g_idx_2bpp
      assign pix_idx = shift_q[7:6];
    end
  endgenerate

  // Palette; reset dominates a coincident write.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pal_q[0] <= 3'b000;
      pal_q[1] <= 3'b111;
      pal_q[2] <= 3'b010;
      pal_q[3] <= 3'b101;
    end else if (pal_wr_i) begin
      pal_q[pal_idx_i] <= pal_data_i;
    end
  end

  // Video decode for the current position, registered below.
  always_comb begin
    hblank_d = (hcount_q >= HW'(H_ACTIVE));
    vblank_d = (vcount_q >= VW'(V_ACTIVE));
    hsync_d  = (hcount_q >= HW'(H_ACTIVE + H_FP)) &&
               (hcount_q <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
    vsync_d  = (vcount_q >= VW'(V_ACTIVE + V_FP)) &&
               (vcount_q <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
    rgb_d    = (hblank_d || vblank_d) ? 3'b000 : pal_q[pix_idx];
  end

  // Output registers: one cycle behind the counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rgb_q    <= 3'b000;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      sync_q   <= 1'b1;
    end else begin
      rgb_q    <= rgb_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      sync_q   <= ~(hsync_d | vsync_d);
    end
  end

  // Interrupt: set entering line V_ACTIVE (beats a coincident ack), cleared by
  // ack or on entering the following line.
  assign irq_set = (hcount_d == '0) && (vcount_d == VW'(V_ACTIVE));
  assign irq_end = (hcount_d == '0) && (vcount_d == VW'(V_ACTIVE + 1));

  always_comb begin
    irq_d = irq_q;
    if (irq_set)
      irq_d = 1'b1;
    else if (irq_ack_i || irq_end)
      irq_d = 1'b0;
  end

  // Interrupt pending flag.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      irq_q <= 1'b0;
    else
      irq_q <= irq_d;
  end

  generate
    if (CPU_BLANK_ONLY != 0) begin : g_wait_active
      logic v_active;
      assign v_active   = (vcount_q < VW'(V_ACTIVE));
      assign cpu_wait_o = cpu_vram_req_i & (v_active | vram_rd_q);
    end else begin : g_wait_fetch
      assign cpu_wait_o = cpu_vram_req_i & vram_rd_q;
    end
  endgenerate

  assign vram_addr_o = addr_q;
  assign vram_rd_o   = vram_rd_q;
  assign red_o       = rgb_q[0];
  assign green_o     = rgb_q[1];
  assign blue_o      = rgb_q[2];
  assign h_blank_o   = hblank_q;
  assign v_blank_o   = vblank_q;
  assign h_sync_o    = hsync_q;
  assign v_sync_o    = vsync_q;
  assign sync_o      = sync_q;
  assign irq_n_o     = ~irq_q;

endmodule
`default_nettype wire

// File: tb/tb_dottori_raster_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dottori_raster_gen                                      |
// | Description : Bench for dottori_raster_gen; a 1 bpp fetch-wait instance  |
// |               and a 2 bpp active-wait instance on a reduced raster,      |
// |               compared each cycle against a positional reference model.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dottori_raster_gen;

  localparam int HA = 32, HF = 4, HS = 4, HB = 4;
  localparam int VA = 8, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, cpu_req = 1'b0, pal_wr = 1'b0, ack = 1'b0;
  logic [1:0] pal_idx = '0;
  logic [2:0] pal_data = '0;
  logic [7:0] data_a = '0, data_b = '0;

  logic [4:0] addr_a;
  logic [5:0] addr_b;
  logic rd_a, wt_a, r_a, g_a, b_a, hs_a, vs_a, hb_a, vb_a, sy_a, irqn_a;
  logic rd_b, wt_b, r_b, g_b, b_b, hs_b, vs_b, hb_b, vb_b, sy_b, irqn_b;

  dottori_raster_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                       .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                       .BPP(1), .CPU_BLANK_ONLY(0), .ADDR_W(5)) u_a (
    .clk_i(clk), .reset_i(reset), .vram_addr_o(addr_a), .vram_rd_o(rd_a),
    .vram_data_i(data_a), .cpu_vram_req_i(cpu_req), .cpu_wait_o(wt_a),
    .pal_wr_i(pal_wr), .pal_idx_i(pal_idx), .pal_data_i(pal_data), .irq_ack_i(ack),
    .red_o(r_a), .green_o(g_a), .blue_o(b_a), .h_sync_o(hs_a), .v_sync_o(vs_a),
    .h_blank_o(hb_a), .v_blank_o(vb_a), .sync_o(sy_a), .irq_n_o(irqn_a));

  dottori_raster_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                       .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                       .BPP(2), .CPU_BLANK_ONLY(1), .ADDR_W(6)) u_b (
    .clk_i(clk), .reset_i(reset), .vram_addr_o(addr_b), .vram_rd_o(rd_b),
    .vram_data_i(data_b), .cpu_vram_req_i(cpu_req), .cpu_wait_o(wt_b),
    .pal_wr_i(pal_wr), .pal_idx_i(pal_idx), .pal_data_i(pal_data), .irq_ack_i(ack),
    .red_o(r_b), .green_o(g_b), .blue_o(b_b), .h_sync_o(hs_b), .v_sync_o(vs_b),
    .h_blank_o(hb_b), .v_blank_o(vb_b), .sync_o(sy_b), .irq_n_o(irqn_b));

  int errors = 0, checks = 0;

  // Reference model state: position in the frame, palette, VRAM images.
  int         pos = FRAME - HT;
  logic [2:0] pm [4];
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [64];
  bit         pending = 1'b0;
  logic [2:0] exp_rgb_a = 3'b000, exp_rgb_b = 3'b000;
  logic [4:0] exp_vid = 5'b11001;
  logic       exp_irqn = 1'b1;

  // Stimulus controls.
  bit         rnd = 1'b0, req_hold = 1'b0;
  int         wr_pos = -1, ack_pos = -1;
  logic [1:0] wr_idx = '0;
  logic [2:0] wr_val = '0;

  bit         prev_rd_a = 1'b0, prev_rd_b = 1'b0;
  logic [4:0] prev_addr_a = '0;
  logic [5:0] prev_addr_b = '0;
  bit         win_ok = 1'b0;
  int         win_rd_a = 0, win_rd_b = 0, win_wt_a = 0, win_wt_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s pos=%0d got=%0h want=%0h", tag, pos, obs, want);
    end
  endtask

  function automatic void pal_defaults();
    pm[0] = 3'b000; pm[1] = 3'b111; pm[2] = 3'b010; pm[3] = 3'b101;
  endfunction

  // {h_blank, v_blank, h_sync, v_sync, sync_n} for a raster position.
  function automatic logic [4:0] vid_of(input int p);
    int h, v;
    logic hsy, vsy;
    h = p % HT; v = p / HT;
    hsy = (h >= HA + HF) && (h < HA + HF + HS);
    vsy = (v >= VA + VF) && (v < VA + VF + VS);
    return {h >= HA, v >= VA, hsy, vsy, !(hsy || vsy)};
  endfunction

  // Colour {B,G,R} shown for a raster position, straight from the bitmap.
  function automatic logic [2:0] rgb_of(input int p, input int bpp);
    int h, v, ppb, j, idx;
    logic [7:0] byt;
    h = p % HT; v = p / HT;
    if (h >= HA || v >= VA) return 3'b000;
    ppb = 8 / bpp;
    j = h % ppb;
    byt = (bpp == 1) ? mem_a[v * (HA / ppb) + h / ppb] : mem_b[v * (HA / ppb) + h / ppb];
    idx = (int'(byt) >> (8 - bpp * (j + 1))) & ((1 << bpp) - 1);
    return pm[idx];
  endfunction

  // A byte must be requested exactly two cycles before its first pixel.
  function automatic bit fetch_due(input int p, input int bpp, output int addr);
    int p2, h2, v2, ppb;
    ppb = 8 / bpp;
    p2 = (p + 2) % FRAME; h2 = p2 % HT; v2 = p2 / HT;
    addr = v2 * (HA / ppb) + h2 / ppb;
    return (v2 < VA) && (h2 < HA) && (h2 % ppb == 0);
  endfunction

  task automatic cycle(input bit rst);
    int  ea, eb;
    bit  fa, fb;
    @(negedge clk);
    reset   = rst;
    data_a  = prev_rd_a ? mem_a[prev_addr_a] : 8'($urandom);
    data_b  = prev_rd_b ? mem_b[prev_addr_b] : 8'($urandom);
    cpu_req = req_hold ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
    pal_idx = 2'($urandom);
    pal_data = 3'($urandom);
    pal_wr  = 1'b0;
    if (pos == wr_pos) begin
      pal_wr = 1'b1; pal_idx = wr_idx; pal_data = wr_val;
    end else if (rnd && $urandom_range(0, 15) == 0) begin
      pal_wr = 1'b1;
    end
    ack = (pos == ack_pos) || (rnd && ack_pos < 0 && $urandom_range(0, 31) == 0);
    #1;
    fa = fetch_due(pos, 1, ea);
    fb = fetch_due(pos, 2, eb);
    chk("rd_a", rd_a, fa);
    chk("rd_b", rd_b, fb);
    if (fa) chk("addr_a", addr_a, ea);
    if (fb) chk("addr_b", addr_b, eb);
    chk("wait_a", wt_a, cpu_req & fa);
    chk("wait_b", wt_b, cpu_req & ((pos / HT) < VA || fb));
    chk("rgb_a", {b_a, g_a, r_a}, exp_rgb_a);
    chk("rgb_b", {b_b, g_b, r_b}, exp_rgb_b);
    chk("vid_a", {hb_a, vb_a, hs_a, vs_a, sy_a}, exp_vid);
    chk("vid_b", {hb_b, vb_b, hs_b, vs_b, sy_b}, exp_vid);
    chk("irqn_a", irqn_a, exp_irqn);
    chk("irqn_b", irqn_b, exp_irqn);
    // Per-frame totals over a whole frame window with the CPU always requesting.
    if (pos == 0) begin
      if (win_ok) begin
        chk("frame_rd_a", win_rd_a, VA * (HA / 8));
        chk("frame_rd_b", win_rd_b, VA * (HA / 4));
        chk("frame_wait_a", win_wt_a, VA * (HA / 8));
        chk("frame_wait_b", win_wt_b, VA * HT + 1);
      end
      win_rd_a = 0; win_rd_b = 0; win_wt_a = 0; win_wt_b = 0;
      win_ok = req_hold && !rst;
    end
    if (!req_hold) win_ok = 1'b0;
    win_rd_a += int'(rd_a); win_rd_b += int'(rd_b);
    win_wt_a += int'(wt_a); win_wt_b += int'(wt_b);
    prev_rd_a = rd_a; prev_addr_a = addr_a;
    prev_rd_b = rd_b; prev_addr_b = addr_b;
    // Advance the model across the coming edge.
    if (rst) begin
      exp_rgb_a = 3'b000; exp_rgb_b = 3'b000; exp_vid = 5'b11001; exp_irqn = 1'b1;
      pos = FRAME - HT; pending = 1'b0; win_ok = 1'b0;
      pal_defaults();
    end else begin
      exp_vid   = vid_of(pos);
      exp_rgb_a = rgb_of(pos, 1);
      exp_rgb_b = rgb_of(pos, 2);
      if (pal_wr) pm[pal_idx] = pal_data;
      pos = (pos + 1) % FRAME;
      if (pos == VA * HT) pending = 1'b1;
      else if (ack || pos == (VA + 1) * HT) pending = 1'b0;
      exp_irqn = !pending;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    pal_defaults();
    for (int i = 0; i < 32; i++) mem_a[i] = 8'h81;
    for (int i = 0; i < 64; i++) mem_b[i] = 8'hE4;
    repeat (2) @(posedge clk);
    // Reset state held for a few cycles.
    for (int i = 0; i < 3; i++) cycle(1'b1);

    // Constant bitmaps, CPU requesting throughout; mid-line write of entry 1 to red.
    req_hold = 1'b1;
    wr_pos = 2 * HT + 5; wr_idx = 2'd1; wr_val = 3'b001;
    run(2 * FRAME + 4);

    // Random traffic, then a reset landing inside an active line.
    req_hold = 1'b0; wr_pos = -1; rnd = 1'b1;
    run(3 * HT + 13);
    cycle(1'b1);
    for (int i = 0; i < 32; i++) mem_a[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);

    // Ack mid-line 8, then an ack coinciding with the setting edge, then random.
    ack_pos = VA * HT + 10;
    run(FRAME);
    ack_pos = VA * HT - 1;
    run(FRAME);
    ack_pos = -1;
    run(FRAME);

    // Reset together with a palette write: the reset palette must win.
    wr_pos = pos; wr_idx = 2'd1; wr_val = 3'b110;
    cycle(1'b1);
    wr_pos = -1;
    run(FRAME + 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
